halflife_input_conditioner: RTL and testbench

//  Upstream stage of the half-life timer counter. Conditions raw asynchronous
//  pad inputs into clean single-cycle command strobes.
//  - Synchronises and debounces the up/down/load buttons.
//  - Emits one-cycle up/down/load pulses with auto-repeat on held up/down.
//  - Presents a stable 4-bit load value aligned with the load pulse.
//  - Outputs drive the counter's up, down, load and in inputs directly.

---
 rtl/halflife_input_conditioner.sv | 163 ++++++++++++++++
 tb/tb_halflife_input_conditioner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/halflife_input_conditioner.sv
// Input conditioner for the half-life timer counter: synchronises and debounces the
// raw pad buttons and turns them into single-cycle up/down/load command strobes.
module halflife_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_load,
    input  logic [3:0] din,
    output logic       up,
    output logic       down,
    output logic       load,
    output logic [3:0] load_val
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST  = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } state_t;

    // Bit order for the button vectors: 0 = up, 1 = down, 2 = load
    logic [2:0]    btn_meta;
    logic [2:0]    btn_sync;
    logic [3:0]    din_meta;
    logic [3:0]    din_sync;
    logic [2:0]    deb;
    logic [DW-1:0] deb_cnt [3];

    state_t        rep_state [2];
    logic [RW-1:0] rep_cnt   [2];
    state_t        ld_state;

    logic [1:0]    rep_due;
    logic          load_due;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            din_meta <= '0;
            din_sync <= '0;
        end else begin
            btn_meta <= {btn_load, btn_down, btn_up};
            btn_sync <= btn_meta;
            din_meta <= din;
            din_sync <= din_meta;
        end
    end

    // The debounced level only flips after the synced level has disagreed for a full run
    always_ff @(posedge clk) begin
        if (reset) begin
            deb <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (btn_sync[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= btn_sync[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        rep_due = '0;
        for (int i = 0; i < 2; i++) begin
            case (rep_state[i])
                IDLE:    rep_due[i] = deb[i];
                HELD:    rep_due[i] = deb[i] && (REPEAT_DELAY != 0) && (rep_cnt[i] == RD_LAST);
                REPEAT:  rep_due[i] = deb[i] && (rep_cnt[i] == RP_LAST);
                default: rep_due[i] = 1'b0;
            endcase
        end
        load_due = (ld_state == IDLE) && deb[2];
    end

    // Button FSMs plus registered strobes; arbitration drops pulses without disturbing FSM timing
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                rep_state[i] <= IDLE;
                rep_cnt[i]   <= '0;
            end
            ld_state <= IDLE;
            up       <= 1'b0;
            down     <= 1'b0;
            load     <= 1'b0;
            load_val <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (rep_state[i])
                    IDLE: begin
                        if (deb[i]) begin
                            rep_state[i] <= HELD;
                            rep_cnt[i]   <= '0;
                        end
                    end
                    HELD: begin
                        if (!deb[i]) begin
                            rep_state[i] <= IDLE;
                        end else if (REPEAT_DELAY != 0) begin
                            if (rep_cnt[i] == RD_LAST) begin
                                rep_state[i] <= REPEAT;
                                rep_cnt[i]   <= '0;
                            end else begin
                                rep_cnt[i] <= rep_cnt[i] + 1'b1;
                            end
                        end
                    end
                    REPEAT: begin
                        if (!deb[i]) begin
                            rep_state[i] <= IDLE;
                        end else if (rep_cnt[i] == RP_LAST) begin
                            rep_cnt[i] <= '0;
                        end else begin
                            rep_cnt[i] <= rep_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        rep_state[i] <= IDLE;
                        rep_cnt[i]   <= '0;
                    end
                endcase
            end

            case (ld_state)
                IDLE:    if (deb[2]) ld_state <= HELD;
                HELD:    if (!deb[2]) ld_state <= IDLE;
                default: ld_state <= IDLE;
            endcase

            up   <= rep_due[0] && !rep_due[1] && !load_due;
            down <= rep_due[1] && !rep_due[0] && !load_due;
            load <= load_due;
            if (load_due) begin
                load_val <= din_sync;
            end
        end
    end

endmodule

// File: tb/tb_halflife_input_conditioner.sv
// Directed self-checking bench for halflife_input_conditioner with short debounce
// and repeat timing (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8).
module tb_halflife_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_load;
    logic [3:0] din;
    logic       up;
    logic       down;
    logic       load;
    logic [3:0] load_val;

    int checks = 0;
    int errors = 0;

    halflife_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .btn_load(btn_load),
        .din     (din),
        .up      (up),
        .down    (down),
        .load    (load),
        .load_val(load_val)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_load = 1'b0;
        din      = 4'h0;
        tick();
        tick();
        checks++;
        if (up !== 1'b0) begin errors++; $display("[TB] FAIL reset_up got %b want 0", up); end
        checks++;
        if (down !== 1'b0) begin errors++; $display("[TB] FAIL reset_down got %b want 0", down); end
        checks++;
        if (load !== 1'b0) begin errors++; $display("[TB] FAIL reset_load got %b want 0", load); end
        checks++;
        if (load_val !== 4'h0) begin errors++; $display("[TB] FAIL reset_load_val got %h want 0", load_val); end
        reset = 1'b0;
        idle_cycles(3);
    endtask

    // Six raw samples high; the single pulse appears after the 7th tick (edge N+6)
    task automatic test_single_press();
        logic exp_up;
        btn_up = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 6) btn_up = 1'b0;
            exp_up = (k == 7);
            checks++;
            if (up !== exp_up) begin errors++; $display("[TB] FAIL single_up k=%0d got %b want %b", k, up, exp_up); end
            checks++;
            if (down !== 1'b0 || load !== 1'b0) begin
                errors++; $display("[TB] FAIL single_others k=%0d got down=%b load=%b want 0", k, down, load);
            end
        end
    endtask

    task automatic test_glitch();
        btn_down = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 3) btn_down = 1'b0;
            checks++;
            if (down !== 1'b0 || up !== 1'b0) begin
                errors++; $display("[TB] FAIL glitch k=%0d got up=%b down=%b want 0", k, up, down);
            end
        end
    endtask

    // Pulses at edges N+6, N+26 and every 8 after that while the debounced level is high
    task automatic test_auto_repeat();
        logic exp_up;
        int   e;
        btn_up = 1'b1;
        for (int k = 1; k <= 85; k++) begin
            tick();
            if (k == 60) btn_up = 1'b0;
            e      = k - 1;
            exp_up = (e == 6) || (e >= 26 && e <= 58 && ((e - 26) % 8) == 0);
            checks++;
            if (up !== exp_up) begin errors++; $display("[TB] FAIL repeat_up edge=N+%0d got %b want %b", e, up, exp_up); end
        end
    endtask

    task automatic test_load();
        logic exp_load;
        din      = 4'hA;
        btn_load = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 6) btn_load = 1'b0;
            exp_load = (k == 7);
            checks++;
            if (load !== exp_load) begin errors++; $display("[TB] FAIL load_pulse k=%0d got %b want %b", k, load, exp_load); end
            if (k == 7) begin
                checks++;
                if (load_val !== 4'hA) begin errors++; $display("[TB] FAIL load_val_capture got %h want a", load_val); end
            end
        end
        din = 4'h3;
        idle_cycles(12);
        checks++;
        if (load_val !== 4'hA) begin errors++; $display("[TB] FAIL load_val_hold got %h want a", load_val); end
        checks++;
        if (load !== 1'b0) begin errors++; $display("[TB] FAIL load_idle got %b want 0", load); end
    endtask

    task automatic test_arbitration();
        logic exp_load;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 6) begin
                btn_up   = 1'b0;
                btn_down = 1'b0;
            end
            checks++;
            if (up !== 1'b0 || down !== 1'b0) begin
                errors++; $display("[TB] FAIL updown_clash k=%0d got up=%b down=%b want 0", k, up, down);
            end
        end
        btn_up   = 1'b1;
        btn_load = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 6) begin
                btn_up   = 1'b0;
                btn_load = 1'b0;
            end
            exp_load = (k == 7);
            checks++;
            if (up !== 1'b0) begin errors++; $display("[TB] FAIL upload_up k=%0d got %b want 0", k, up); end
            checks++;
            if (load !== exp_load) begin errors++; $display("[TB] FAIL upload_load k=%0d got %b want %b", k, load, exp_load); end
            if (k == 7) begin
                checks++;
                if (load_val !== 4'h3) begin errors++; $display("[TB] FAIL upload_load_val got %h want 3", load_val); end
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        logic exp_up;
        btn_up = 1'b1;
        idle_cycles(30);
        reset = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (up !== 1'b0 || down !== 1'b0 || load !== 1'b0) begin
                errors++; $display("[TB] FAIL midreset_outputs k=%0d got up=%b down=%b load=%b want 0", k, up, down, load);
            end
            checks++;
            if (load_val !== 4'h0) begin errors++; $display("[TB] FAIL midreset_load_val got %h want 0", load_val); end
        end
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_up = (k == 7);
            checks++;
            if (up !== exp_up) begin errors++; $display("[TB] FAIL postreset_up k=%0d got %b want %b", k, up, exp_up); end
        end
        btn_up = 1'b0;
        idle_cycles(12);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_auto_repeat();
        test_load();
        test_arbitration();
        test_reset_mid_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
